// File: rtl/axis_src_pkg.sv
// Shared types and helpers for the AXI-Stream message source.
package axis_src_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_e;

   localparam int DEF_DEPTH = 16;
   localparam int ADDR_W    = $clog2(DEF_DEPTH);
   localparam int LEN_W     = ADDR_W + 1;

   // Packet length never exceeds the buffer size.
   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
      return (len > depth) ? depth : len;
   endfunction

endpackage

// File: rtl/msg_buf_ram.sv
// Message buffer: DEPTH x WIDTH register array, synchronous write,
// asynchronous read, cleared by reset.
module msg_buf_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/axis_msg_stream_src.sv
// AXI-Stream message source: replays a loaded buffer as one or more packets,
// with TLAST on the final beat of each pass.
module axis_msg_stream_src
   import axis_src_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int PASS_W = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [$clog2(DEPTH)-1:0]  wr_addr,
   input  logic [WIDTH-1:0]          wr_data,
   output logic                      wr_err,
   input  logic                      start,
   input  logic                      stop,
   input  logic [$clog2(DEPTH):0]    cfg_len,
   input  logic [PASS_W-1:0]         cfg_passes,
   output logic [WIDTH-1:0]          m_axis_data,
   output logic                      m_axis_valid,
   output logic                      m_axis_last,
   input  logic                      m_axis_ready,
   output logic                      busy,
   output logic                      done,
   output logic [PASS_W-1:0]         pass_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   state_e            state_q, state_d;
   logic [AW-1:0]     ptr_q, ptr_d;
   logic [LW-1:0]     len_q, len_d;
   logic [PASS_W-1:0] passes_q, passes_d;
   logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
   logic              stop_pend_q, stop_pend_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic              done_q, done_d;
   logic              wr_err_q, wr_err_d;

   logic [WIDTH-1:0]  rd_data;
   logic              buf_we;
   logic              load_en;
   logic              hs;
   logic              ptr_at_last;
   logic              run_end;

   assign buf_we      = wr_en && (state_q == IDLE);
   assign load_en     = !valid_q || m_axis_ready;
   assign hs          = valid_q && m_axis_ready;
   assign ptr_at_last = ({1'b0, ptr_q} == (len_q - LW'(1)));

   msg_buf_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .we      (buf_we),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (ptr_q),
      .rd_data (rd_data)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      len_d       = len_q;
      passes_d    = passes_q;
      pass_cnt_d  = pass_cnt_q;
      stop_pend_d = stop_pend_q;
      data_d      = data_q;
      valid_d     = valid_q;
      last_d      = last_q;
      done_d      = 1'b0;
      wr_err_d    = 1'b0;
      run_end     = 1'b0;

      case (state_q)
         IDLE: begin
            stop_pend_d = 1'b0;
            if (start && (cfg_len != '0)) begin
               len_d      = LW'(clamp_len(32'(cfg_len), DEPTH));
               passes_d   = cfg_passes;
               pass_cnt_d = '0;
               ptr_d      = '0;
               state_d    = STREAM;
            end
         end
         STREAM: begin
            wr_err_d = wr_en;
            if (hs && last_q) begin
               pass_cnt_d = pass_cnt_q + PASS_W'(1);
               run_end    = stop_pend_q || stop ||
                            ((passes_q != '0) && ((pass_cnt_q + PASS_W'(1)) == passes_q));
            end
            if (run_end) begin
               // Final TLAST accepted: retire the stream without loading another beat.
               valid_d     = 1'b0;
               last_d      = 1'b0;
               done_d      = 1'b1;
               stop_pend_d = 1'b0;
               state_d     = IDLE;
            end else begin
               if (stop) stop_pend_d = 1'b1;
               if (load_en) begin
                  data_d  = rd_data;
                  valid_d = 1'b1;
                  last_d  = ptr_at_last;
                  ptr_d   = ptr_at_last ? '0 : ptr_q + AW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         len_q       <= '0;
         passes_q    <= '0;
         pass_cnt_q  <= '0;
         stop_pend_q <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         done_q      <= 1'b0;
         wr_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         len_q       <= len_d;
         passes_q    <= passes_d;
         pass_cnt_q  <= pass_cnt_d;
         stop_pend_q <= stop_pend_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         last_q      <= last_d;
         done_q      <= done_d;
         wr_err_q    <= wr_err_d;
      end
   end

   assign m_axis_data  = data_q;
   assign m_axis_valid = valid_q;
   assign m_axis_last  = last_q;
   assign busy         = (state_q == STREAM);
   assign done         = done_q;
   assign wr_err       = wr_err_q;
   assign pass_cnt     = pass_cnt_q;

endmodule

// File: tb/tb_axis_msg_stream_src.sv
// Self-checking bench for axis_msg_stream_src: table-driven runs, hand-written
// corner sequences and randomized runs against a packet-level reference model.
module tb_axis_msg_stream_src;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 16;
   localparam int PASS_W = 8;
   localparam int AW     = 4;
   localparam int LW     = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              wr_err;
   logic              start;
   logic              stop;
   logic [LW-1:0]     cfg_len;
   logic [PASS_W-1:0] cfg_passes;
   logic [WIDTH-1:0]  m_axis_data;
   logic              m_axis_valid;
   logic              m_axis_last;
   logic              m_axis_ready;
   logic              busy;
   logic              done;
   logic [PASS_W-1:0] pass_cnt;

   always #5 clk = ~clk;

   axis_msg_stream_src #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .PASS_W (PASS_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_err       (wr_err),
      .start        (start),
      .stop         (stop),
      .cfg_len      (cfg_len),
      .cfg_passes   (cfg_passes),
      .m_axis_data  (m_axis_data),
      .m_axis_valid (m_axis_valid),
      .m_axis_last  (m_axis_last),
      .m_axis_ready (m_axis_ready),
      .busy         (busy),
      .done         (done),
      .pass_cnt     (pass_cnt)
   );

   typedef struct {
      int len;
      int passes;
      int rmode;      // 0: ready high, 1: pattern 1,0,0,1, 2: random
      int stop_beat;  // beat index at which stop is pulsed, -1 for none
      int exp_beats;
      int exp_pc;
   } run_vec_t;

   int n_vec = 0;
   int n_bad = 0;
   logic [WIDTH-1:0] mem_m [DEPTH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clamp(input int len);
      return (len > DEPTH) ? DEPTH : len;
   endfunction

   task automatic write_mem(input int a, input logic [WIDTH-1:0] d);
      wr_addr = AW'(a);
      wr_data = d;
      wr_en   = 1'b1;
      @(negedge clk);
      wr_en    = 1'b0;
      mem_m[a] = d;
      check("wr_err_idle", 32'(wr_err), 0);
   endtask

   // Issues start and checks the one-cycle bubble before the first beat.
   // With poke set, a buffer write is attempted during the run.
   task automatic start_run(input int len, input int passes, input bit poke);
      cfg_len      = LW'(len);
      cfg_passes   = PASS_W'(passes);
      stop         = 1'b0;
      m_axis_ready = 1'b0;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_busy", 32'(busy), 1);
      check("start_bubble", 32'(m_axis_valid), 0);
      if (poke) begin
         wr_addr = AW'(2);
         wr_data = 8'hEE;
         wr_en   = 1'b1;
      end
      @(negedge clk);
      wr_en = 1'b0;
      if (poke) check("wr_err_pulse", 32'(wr_err), 1);
      check("first_valid", 32'(m_axis_valid), 1);
   endtask

   // Consumes beats until done, checking each accepted beat against the model.
   task automatic drain(input int len, input int rmode, input int stop_beat,
                        input int exp_beats, input int exp_pc);
      int L;
      int beats;
      int cyc;
      bit seen_done;
      bit pstall;
      bit stop_sent;
      logic [WIDTH-1:0] pd;
      logic pl;
      L = clamp(len);
      beats = 0; cyc = 0; seen_done = 0; pstall = 0; stop_sent = 0;
      pd = '0; pl = 1'b0;
      while (!seen_done && cyc < 2000) begin
         if (pstall) begin
            check("stall_valid", 32'(m_axis_valid), 1);
            check("stall_data", 32'(m_axis_data), 32'(pd));
            check("stall_last", 32'(m_axis_last), 32'(pl));
         end
         if (done) begin
            seen_done = 1;
         end else begin
            case (rmode)
               0:       m_axis_ready = 1'b1;
               1:       m_axis_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
               default: m_axis_ready = 1'($urandom_range(0, 1));
            endcase
            if (!stop_sent && stop_beat >= 0 && m_axis_valid && beats == stop_beat) begin
               stop      = 1'b1;
               stop_sent = 1;
            end
            if (m_axis_valid && m_axis_ready) begin
               check("beat_data", 32'(m_axis_data), 32'(mem_m[beats % L]));
               check("beat_last", 32'(m_axis_last), 32'((beats % L) == (L - 1)));
               beats++;
            end
            pstall = m_axis_valid && !m_axis_ready;
            pd     = m_axis_data;
            pl     = m_axis_last;
            @(negedge clk);
            stop = 1'b0;
            cyc++;
         end
      end
      m_axis_ready = 1'b0;
      if (!seen_done) check("done_timeout", 0, 1);
      check("run_beats", 32'(beats), 32'(exp_beats));
      check("run_pass_cnt", 32'(pass_cnt), 32'(exp_pc));
      check("end_valid", 32'(m_axis_valid), 0);
      check("end_busy", 32'(busy), 0);
      if (rmode == 0) check("no_bubbles", 32'(cyc), 32'(exp_beats));
      @(negedge clk);
      check("done_pulse_width", 32'(done), 0);
   endtask

   initial begin
      run_vec_t tbl[$];
      logic [WIDTH-1:0] hello [6];

      rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; stop = 1'b0;
      cfg_len = '0; cfg_passes = '0; m_axis_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      check("rst_valid", 32'(m_axis_valid), 0);
      check("rst_last", 32'(m_axis_last), 0);
      check("rst_data", 32'(m_axis_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_wr_err", 32'(wr_err), 0);
      check("rst_pass_cnt", 32'(pass_cnt), 0);

      hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0A};
      for (int i = 0; i < 6; i++) write_mem(i, hello[i]);
      for (int i = 6; i < DEPTH; i++) write_mem(i, 8'($urandom));

      tbl.push_back('{len: 6,  passes: 1, rmode: 0, stop_beat: -1, exp_beats: 6,  exp_pc: 1});
      tbl.push_back('{len: 6,  passes: 3, rmode: 1, stop_beat: -1, exp_beats: 18, exp_pc: 3});
      tbl.push_back('{len: 4,  passes: 0, rmode: 0, stop_beat: 17, exp_beats: 20, exp_pc: 5});
      tbl.push_back('{len: 31, passes: 1, rmode: 0, stop_beat: -1, exp_beats: 16, exp_pc: 1});
      tbl.push_back('{len: 1,  passes: 4, rmode: 0, stop_beat: -1, exp_beats: 4,  exp_pc: 4});
      tbl.push_back('{len: 16, passes: 2, rmode: 2, stop_beat: -1, exp_beats: 32, exp_pc: 2});
      tbl.push_back('{len: 3,  passes: 0, rmode: 2, stop_beat: 0,  exp_beats: 3,  exp_pc: 1});
      tbl.push_back('{len: 4,  passes: 0, rmode: 1, stop_beat: 3,  exp_beats: 4,  exp_pc: 1});
      tbl.push_back('{len: 5,  passes: 2, rmode: 0, stop_beat: 2,  exp_beats: 5,  exp_pc: 1});

      foreach (tbl[k]) begin
         start_run(tbl[k].len, tbl[k].passes, 1'b0);
         drain(tbl[k].len, tbl[k].rmode, tbl[k].stop_beat, tbl[k].exp_beats, tbl[k].exp_pc);
      end

      // Write during a run is dropped and flagged; the buffer keeps its contents.
      start_run(6, 1, 1'b1);
      drain(6, 2, -1, 6, 1);
      start_run(6, 1, 1'b0);
      drain(6, 0, -1, 6, 1);

      // Zero length start is ignored.
      cfg_len = '0; cfg_passes = PASS_W'(1); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("len0_busy", 32'(busy), 0);
         check("len0_valid", 32'(m_axis_valid), 0);
         @(negedge clk);
      end

      // Asynchronous reset while a beat is stalled mid-packet.
      start_run(6, 0, 1'b0);
      m_axis_ready = 1'b0;
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("arst_valid", 32'(m_axis_valid), 0);
      check("arst_last", 32'(m_axis_last), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_data", 32'(m_axis_data), 0);
      check("arst_pass_cnt", 32'(pass_cnt), 0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      @(negedge clk);
      start_run(2, 1, 1'b0);
      drain(2, 0, -1, 2, 1);
      start_run(16, 1, 1'b0);
      drain(16, 2, -1, 16, 1);

      // Randomized runs against the packet-level model.
      for (int r = 0; r < 12; r++) begin
         int len, L, passes, sb, pk;
         for (int j = 0; j < 3; j++) write_mem(int'($urandom_range(0, DEPTH - 1)), 8'($urandom));
         len    = int'($urandom_range(1, 20));
         L      = clamp(len);
         passes = int'($urandom_range(0, 3));
         if (passes == 0) sb = int'($urandom_range(0, 3 * L - 1));
         else if ($urandom_range(0, 3) == 0) sb = int'($urandom_range(0, L * passes - 1));
         else sb = -1;
         if (passes == 0)  pk = sb / L + 1;
         else if (sb < 0)  pk = passes;
         else              pk = (sb / L + 1 < passes) ? sb / L + 1 : passes;
         start_run(len, passes, 1'b0);
         drain(len, 2, sb, pk * L, pk % 256);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/axis_msg_stream_src.md
Name: axis_msg_stream_src

Overview:
- Parametrised AXI-Stream message source.
- An external controller loads a DEPTH-entry message buffer, then starts a stream of cfg_len beats.
- Each pass through the buffer is one packet, with TLAST on its final beat.
- Streams one or more passes with full AXI-Stream compliance: valid held until ready, data stable while stalled, one beat per cycle when ready stays high.
- Sits between the test/control logic and the downstream UART TX FIFO.

Parameters:
- WIDTH, 8, data beat width in bits.
- DEPTH, 16, message buffer entries; must be a power of 2, ≥2.
- PASS_W, 8, width of the pass-count config.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  $clog2(DEPTH)  buffer write index.
- wr_data  in  WIDTH  buffer write data.
- wr_err  out  1  1-cycle pulse: write attempted while busy (write dropped).
- start  in  1  begin streaming; sampled only in IDLE.
- stop  in  1  graceful stop request.
- cfg_len  in  $clog2(DEPTH)+1  beats per packet; latched on start.
- cfg_passes  in  PASS_W  packets to send; 0 = continuous until stop; latched on start.
- m_axis_data  out  WIDTH  stream data.
- m_axis_valid  out  1  stream valid.
- m_axis_last  out  1  last beat of packet.
- m_axis_ready  in  1  downstream ready.
- busy  out  1  high in STREAM state.
- done  out  1  1-cycle pulse after the final beat handshake.
- pass_cnt  out  PASS_W  completed packets in the current run; wraps.

Behaviour:
- Reset (rst=0, async):
  - Outputs: m_axis_valid=0, m_axis_last=0, m_axis_data=0, busy=0, done=0, wr_err=0, pass_cnt=0.
  - Internal: all buffer entries 0, state=IDLE, read pointer 0, stop_pend=0.
  - Reset mid-packet drops the packet immediately; no TLAST is emitted.
- Handshake: beat transfers on m_axis_valid && m_axis_ready. The output register loads only when load_en = !m_axis_valid || m_axis_ready.
- IDLE:
  - Writes go to the buffer: mem[wr_addr] <= wr_data.
  - start with cfg_len==0: ignored.
  - start otherwise: latch len = min(cfg_len, DEPTH) and passes; clear pass_cnt and ptr; go to STREAM.
  - A write in the same cycle as an accepted start is committed.
- STREAM:
  - On each edge with load_en and no pending end: m_axis_data <= mem[ptr]; m_axis_valid <= 1; m_axis_last <= (ptr==len-1).
  - Then ptr <= (ptr==len-1) ? 0 : ptr+1.
  - First beat is valid 2 cycles after the start-sample edge (1 idle bubble); back-to-back afterwards.
  - Packet boundary: pass_cnt increments on each handshake with m_axis_last=1.
- End condition, evaluated at a TLAST handshake. The run ends if either holds:
  - stop_pend, or stop in the same cycle; or
  - passes!=0 and pass_cnt+1==passes.
- On end: m_axis_valid <= 0 at that edge; state -> IDLE; busy -> 0; done=1 for the next cycle; no further beats are loaded.
- Otherwise the stream continues without a bubble into the next packet, starting at mem[0].
- stop:
  - In STREAM: sets stop_pend; the current packet always completes with TLAST, so packets are never truncated.
  - In IDLE: no effect. stop_pend clears on entry to IDLE.
- Stall: while m_axis_valid && !m_axis_ready, data, last and ptr are held unchanged.
- wr_en in STREAM: write dropped; wr_err pulses next cycle. Buffer contents stay frozen for the whole run.
- start while busy: ignored.
- cfg_len > DEPTH: clamped to DEPTH.
- cfg_len==1: every beat has last=1.
- pass_cnt width: wraps modulo 2^PASS_W in continuous mode.

Decomposition:
- Package axis_src_pkg:
  - state enum {IDLE, STREAM};
  - localparams ADDR_W=$clog2(DEPTH) and LEN_W=ADDR_W+1;
  - a function clamping len to DEPTH.
- One natural sub-module, msg_buf_ram: DEPTH x WIDTH register array with synchronous write and asynchronous read, plus async-reset clear.
- Control FSM and output register stay in the top.

Test Plan:
- Load "HELLO\n" (0x48,0x45,0x4C,0x4C,0x4F,0x0A) at 0..5; start with len=6, passes=1, ready=1.
  - Expect valid rising 2 cycles after start and 6 consecutive beats with last only on 0x0A.
  - Expect done pulse the next cycle, pass_cnt=1, busy=0.
- Same load; passes=3; ready toggling 1,0,0,1 repeating.
  - Expect 18 beats, data stable across every stall cycle, last on beats 6/12/18.
  - Expect pass_cnt=3, then done.
- passes=0 with len=4; assert stop mid-way through packet 5 (2nd beat).
  - Expect packet 5 to finish fully with TLAST on 4th beat, then valid=0, done, pass_cnt=5.
- wr_en to addr 2 during STREAM → wr_err pulse; next run still reads the original mem[2].
  - Also: start with cfg_len=0 → no valid, busy stays 0.
  - Also: cfg_len=31 with DEPTH=16 → 16-beat packets.
- Assert rst=0 asynchronously mid-packet (between edges) with ready=0.
  - Expect valid, last, busy to drop immediately and buffer reads back 0.
  - After release, start with len=2 streams 0x00,0x00.
- cfg_len=1, passes=4, ready=1 → 4 back-to-back beats of mem[0], each with last=1, pass_cnt=4.
